// File: rtl/sr_bank_ctrl_pkg.sv
// Shared definitions for the SR flag bank controller.
//   state_t : controller FSM states (IDLE -> DRIVE -> RELEASE -> IDLE)
//   OP_SET  : opcode driving the cell's s input
//   OP_RST  : opcode driving the cell's r input
package sr_bank_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DRIVE   = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   localparam logic OP_SET = 1'b1;
   localparam logic OP_RST = 1'b0;

endpackage

// File: rtl/sr_bank_ctrl_cell.sv
// sr_cell: one clocked SR flag.
//   clk, rst : clock, async active-high reset (q -> 0)
//   s, r     : set / reset request, sampled on rising edge
//   q        : flag value
// s=r=1 holds the current value; the controller never produces it, but the
// cell stays well defined if it ever did.
module sr_cell (
   input  logic clk,
   input  logic rst,
   input  logic s,
   input  logic r,
   output logic q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)            q <= 1'b0;
      else if (s && !r)   q <= 1'b1;
      else if (r && !s)   q <= 1'b0;
   end

endmodule

// File: rtl/sr_bank_ctrl.sv
// sr_bank_ctrl: round-robin arbiter + sequencer for a bank of SR flag cells.
// One command is granted at a time; the target cell's s or r is held for HOLD
// cycles, then a one-cycle RELEASE reports completion.
//   clk, rst : clock, async active-high reset
//   req      : per-requester level request
//   op       : per-requester opcode (1 = set, 0 = reset)
//   idx      : per-requester flag index, requester i at [i*IDXW +: IDXW]
//   gnt      : one-hot grant pulse
//   done     : completion pulse, done_id = flag index of that command
//   err      : pulses with gnt when the granted index is >= NFLAG
//   busy     : high whenever the controller is not idle
//   q        : flag cell outputs
module sr_bank_ctrl
   import sr_bank_ctrl_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int NFLAG = 6,
   parameter int IDXW  = 3,
   parameter int HOLD  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      op,
   input  logic [NREQ*IDXW-1:0] idx,
   output logic [NREQ-1:0]      gnt,
   output logic                 done,
   output logic [IDXW-1:0]      done_id,
   output logic                 err,
   output logic                 busy,
   output logic [NFLAG-1:0]     q
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (HOLD > 1) ? $clog2(HOLD + 1) : 1;

   state_t              state, state_n;
   logic [PW-1:0]       ptr, ptr_n;
   logic [CW-1:0]       cnt, cnt_n;
   logic                op_q, op_n;
   logic [IDXW-1:0]     idx_q, idx_n;
   logic [NREQ-1:0]     gnt_n;
   logic                done_n, err_n;
   logic [IDXW-1:0]     done_id_n;

   logic [NREQ-1:0][IDXW-1:0] idx_a;
   logic                      found;
   logic [PW-1:0]             win;
   logic [NFLAG-1:0]          s, r;

   assign idx_a = idx;

   // Round-robin pick: first requester at or after ptr, wrapping.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NREQ; k++) begin
         int            jn;
         logic [PW-1:0] jp;
         jn = int'(ptr) + k;
         if (jn >= NREQ) jn = jn - NREQ;
         jp = PW'(jn);
         if (!found && req[jp]) begin
            found = 1'b1;
            win   = jp;
         end
      end
   end

   always_comb begin
      state_n   = state;
      ptr_n     = ptr;
      cnt_n     = cnt;
      op_n      = op_q;
      idx_n     = idx_q;
      gnt_n     = '0;
      err_n     = 1'b0;
      done_n    = 1'b0;
      done_id_n = done_id;
      case (state)
         ST_IDLE: begin
            if (found) begin
               op_n       = op[win];
               idx_n      = idx_a[win];
               gnt_n[win] = 1'b1;
               err_n      = ({1'b0, idx_a[win]} >= (IDXW+1)'(NFLAG));
               ptr_n      = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
               cnt_n      = CW'(HOLD - 1);
               state_n    = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            // cnt counts down remaining DRIVE cycles; 0 means this is the last.
            if (cnt == '0) begin
               state_n   = ST_RELEASE;
               done_n    = 1'b1;
               done_id_n = idx_q;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         ST_RELEASE: state_n = ST_IDLE;
         default:    state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         ptr     <= '0;
         cnt     <= '0;
         op_q    <= OP_RST;
         idx_q   <= '0;
         gnt     <= '0;
         err     <= 1'b0;
         done    <= 1'b0;
         done_id <= '0;
         busy    <= 1'b0;
      end else begin
         state   <= state_n;
         ptr     <= ptr_n;
         cnt     <= cnt_n;
         op_q    <= op_n;
         idx_q   <= idx_n;
         gnt     <= gnt_n;
         err     <= err_n;
         done    <= done_n;
         done_id <= done_id_n;
         busy    <= (state_n != ST_IDLE);
      end
   end

   // Only the addressed cell is driven, and only one of s/r; an out-of-range
   // index matches no cell so nothing is driven.
   always_comb begin
      s = '0;
      r = '0;
      if (state == ST_DRIVE) begin
         for (int k = 0; k < NFLAG; k++) begin
            if (idx_q == IDXW'(k)) begin
               s[k] = (op_q == OP_SET);
               r[k] = (op_q == OP_RST);
            end
         end
      end
   end

   for (genvar k = 0; k < NFLAG; k++) begin : g_cell
      sr_cell u_cell (
         .clk (clk),
         .rst (rst),
         .s   (s[k]),
         .r   (r[k]),
         .q   (q[k])
      );
   end

endmodule
